// File: rtl/sdram_pkg.sv
// Shared SDRAM-port definitions: bus widths, arbiter state encoding, command payload.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W  = 26;
    localparam int unsigned SDRAM_DATA_W  = 32;
    localparam int unsigned SDRAM_STRB_W  = SDRAM_DATA_W / 8;
    localparam int unsigned SDRAM_BURST_W = 5;

    localparam logic [SDRAM_ADDR_W-1:0] SCREEN_BASE = 26'h3f80000;

    typedef enum logic [2:0] {
        IDLE,
        VGA_CMD,
        VGA_DATA,
        CPU_CMD,
        CPU_WAIT
    } arb_state_e;

    typedef struct packed {
        logic                     write;
        logic [SDRAM_ADDR_W-1:0]  address;
        logic [SDRAM_BURST_W-1:0] burst;
        logic [SDRAM_DATA_W-1:0]  wdata;
        logic [SDRAM_STRB_W-1:0]  wstrb;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_arb_grant.sv
// Grant decision between VGA and CPU with a starvation bound on back-to-back VGA bursts.
module sdram_arb_grant #(
    parameter int unsigned VGA_MAX_CONSEC = 4,
    parameter int unsigned CONSEC_W       = 3
) (
    input  logic                vga_request_i,
    input  logic                cpu_request_i,
    input  logic [CONSEC_W-1:0] consec_i,
    output logic                grant_vga_c_o,
    output logic                grant_cpu_c_o,
    output logic [CONSEC_W-1:0] consec_vga_c_o
);

    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(VGA_MAX_CONSEC);

    logic below_max;

    assign below_max      = (consec_i < CONSEC_MAX);
    assign grant_vga_c_o  = vga_request_i && (!cpu_request_i || below_max);
    assign grant_cpu_c_o  = cpu_request_i && !grant_vga_c_o;
    // Saturates so a long CPU-idle stretch cannot wrap the count back below the bound.
    assign consec_vga_c_o = below_max ? consec_i + CONSEC_W'(1) : consec_i;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM controller port between VGA burst reads and CPU single-word accesses.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned VGA_MAX_CONSEC = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     vga_request,
    input  logic [SDRAM_ADDR_W-1:0]  vga_address,
    output logic [SDRAM_DATA_W-1:0]  vga_rdata,
    output logic                     vga_valid,
    output logic                     vga_complete,
    input  logic                     cpu_request,
    input  logic                     cpu_write,
    input  logic [SDRAM_ADDR_W-1:0]  cpu_address,
    input  logic [SDRAM_DATA_W-1:0]  cpu_wdata,
    input  logic [SDRAM_STRB_W-1:0]  cpu_wstrb,
    output logic [SDRAM_DATA_W-1:0]  cpu_rdata,
    output logic                     cpu_ack,
    output logic                     sdram_request,
    output logic                     sdram_write,
    output logic [SDRAM_ADDR_W-1:0]  sdram_address,
    output logic [SDRAM_BURST_W-1:0] sdram_burst,
    output logic [SDRAM_DATA_W-1:0]  sdram_wdata,
    output logic [SDRAM_STRB_W-1:0]  sdram_wstrb,
    input  logic                     sdram_accept,
    input  logic [SDRAM_DATA_W-1:0]  sdram_rdata,
    input  logic                     sdram_rvalid,
    input  logic                     sdram_done
);

    localparam int unsigned CONSEC_W = $clog2(VGA_MAX_CONSEC + 1);

    arb_state_e              state_q, state_d;
    logic [CONSEC_W-1:0]     consec_q, consec_d;
    sdram_cmd_t              cmd_q, cmd_d;
    logic                    req_q, req_d;
    logic [SDRAM_DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic                    vga_valid_q, vga_valid_d;
    logic                    vga_complete_q, vga_complete_d;
    logic [SDRAM_DATA_W-1:0] rbuf_q, rbuf_d;
    logic [SDRAM_DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                    cpu_ack_q, cpu_ack_d;

    logic                    grant_vga_c;
    logic                    grant_cpu_c;
    logic [CONSEC_W-1:0]     consec_vga_c;

    sdram_arb_grant #(
        .VGA_MAX_CONSEC (VGA_MAX_CONSEC),
        .CONSEC_W       (CONSEC_W)
    ) u_grant (
        .vga_request_i  (vga_request),
        .cpu_request_i  (cpu_request),
        .consec_i       (consec_q),
        .grant_vga_c_o  (grant_vga_c),
        .grant_cpu_c_o  (grant_cpu_c),
        .consec_vga_c_o (consec_vga_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        consec_d       = consec_q;
        cmd_d          = cmd_q;
        req_d          = req_q;
        vga_rdata_d    = vga_rdata_q;
        vga_valid_d    = 1'b0;
        vga_complete_d = 1'b0;
        rbuf_d         = rbuf_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Address is sampled once here; vga_address drifts during the burst.
                if (grant_vga_c) begin
                    state_d       = VGA_CMD;
                    req_d         = 1'b1;
                    consec_d      = consec_vga_c;
                    cmd_d.write   = 1'b0;
                    cmd_d.address = vga_address;
                    cmd_d.burst   = SDRAM_BURST_W'(BURST_LEN);
                    cmd_d.wdata   = '0;
                    cmd_d.wstrb   = '0;
                end else if (grant_cpu_c) begin
                    state_d       = CPU_CMD;
                    req_d         = 1'b1;
                    consec_d      = '0;
                    cmd_d.write   = cpu_write;
                    cmd_d.address = cpu_address;
                    cmd_d.burst   = SDRAM_BURST_W'(1);
                    cmd_d.wdata   = cpu_wdata;
                    cmd_d.wstrb   = cpu_wstrb;
                end
            end
            VGA_CMD: begin
                if (sdram_accept) begin
                    req_d   = 1'b0;
                    state_d = VGA_DATA;
                end
            end
            VGA_DATA: begin
                if (sdram_rvalid) begin
                    vga_valid_d = 1'b1;
                    vga_rdata_d = sdram_rdata;
                end
                if (sdram_done) begin
                    vga_complete_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            CPU_CMD: begin
                if (sdram_accept) begin
                    req_d   = 1'b0;
                    state_d = CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                // Read data is buffered so cpu_rdata only changes together with cpu_ack.
                if (sdram_rvalid && !cmd_q.write) begin
                    rbuf_d = sdram_rdata;
                end
                if (sdram_done) begin
                    cpu_ack_d = 1'b1;
                    state_d   = IDLE;
                    if (!cmd_q.write) begin
                        cpu_rdata_d = sdram_rvalid ? sdram_rdata : rbuf_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            consec_q       <= '0;
            cmd_q          <= '0;
            req_q          <= 1'b0;
            vga_rdata_q    <= '0;
            vga_valid_q    <= 1'b0;
            vga_complete_q <= 1'b0;
            rbuf_q         <= '0;
            cpu_rdata_q    <= '0;
            cpu_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            consec_q       <= consec_d;
            cmd_q          <= cmd_d;
            req_q          <= req_d;
            vga_rdata_q    <= vga_rdata_d;
            vga_valid_q    <= vga_valid_d;
            vga_complete_q <= vga_complete_d;
            rbuf_q         <= rbuf_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_ack_q      <= cpu_ack_d;
        end
    end

    assign vga_rdata     = vga_rdata_q;
    assign vga_valid     = vga_valid_q;
    assign vga_complete  = vga_complete_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign cpu_ack       = cpu_ack_q;
    assign sdram_request = req_q;
    assign sdram_write   = cmd_q.write;
    assign sdram_address = cmd_q.address;
    assign sdram_burst   = cmd_q.burst;
    assign sdram_wdata   = cmd_q.wdata;
    assign sdram_wstrb   = cmd_q.wstrb;

endmodule
